// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates groups of (len+1) unsigned products into one partial sum
// Sum is held registered under backpressure; a new group may start in the same cycle the sum leaves.
module psum_accumulator #(
  parameter int P_WIDTH   = 16,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 prod_valid,
  input  logic [P_WIDTH-1:0]   prod,
  output logic                 prod_ready,
  output logic                 sum_valid,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sum_ovf,
  input  logic                 sum_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;

  logic                 prod_fire;
  logic                 sum_fire;
  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   acc_sum;

  assign sum_valid  = (state_q == HOLD);
  assign sum        = acc_q;
  assign sum_ovf    = ovf_q;
  // In HOLD a product may only enter if the held sum leaves this cycle.
  assign prod_ready = ~rst & ((state_q != HOLD) | sum_ready);
  assign prod_fire  = prod_valid & prod_ready;
  assign sum_fire   = sum_valid & sum_ready;
  assign prod_ext   = (ACC_WIDTH + 1)'(prod);
  assign acc_sum    = {1'b0, acc_q} + prod_ext;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, HOLD: begin
        if (state_q == HOLD && sum_fire && !prod_fire) begin
          state_d = IDLE;
        end else if (prod_fire) begin
          acc_d   = prod_ext[ACC_WIDTH-1:0];
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_fire) begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
          ovf_d = ovf_q | acc_sum[ACC_WIDTH];
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      rem_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator
// Drives a 24-bit and a 16-bit accumulator in parallel against a group-level model.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  len = '0;
  logic        prod_valid = 1'b0;
  logic [15:0] prod = '0;
  logic        sum_ready = 1'b0;

  logic        a_prod_ready, a_sum_valid, a_sum_ovf;
  logic [23:0] a_sum;
  logic        b_prod_ready, b_sum_valid, b_sum_ovf;
  logic [15:0] b_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.P_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(a_prod_ready),
    .sum_valid(a_sum_valid), .sum(a_sum), .sum_ovf(a_sum_ovf), .sum_ready(sum_ready)
  );

  psum_accumulator #(.P_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(b_prod_ready),
    .sum_valid(b_sum_valid), .sum(b_sum), .sum_ovf(b_sum_ovf), .sum_ready(sum_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Group-level model: true (unbounded) totals; wrap and overflow derived per width.
  bit      m_pend;
  bit      m_in_grp;
  int      m_cnt;
  longint  m_tot;
  longint  m_done;

  always @(posedge clk or posedge rst) begin
    bit pr, pf;
    if (rst) begin
      m_pend = 0; m_in_grp = 0; m_cnt = 0; m_tot = 0; m_done = 0;
    end else if (clear) begin
      m_pend = 0; m_in_grp = 0; m_cnt = 0; m_tot = 0; m_done = 0;
    end else begin
      pr = !m_pend || sum_ready;
      pf = prod_valid && pr;
      if (m_pend && sum_ready) m_pend = 0;
      if (pf) begin
        if (!m_in_grp) begin
          m_tot = longint'(prod);
          m_cnt = int'(len);
        end else begin
          m_tot += longint'(prod);
          m_cnt--;
        end
        if (m_cnt == 0) begin
          m_pend = 1; m_done = m_tot; m_in_grp = 0;
        end else begin
          m_in_grp = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_pr;
    exp_pr = !rst && (!m_pend || sum_ready);
    chk("a_prod_ready", a_prod_ready, exp_pr);
    chk("b_prod_ready", b_prod_ready, exp_pr);
    chk("a_sum_valid", a_sum_valid, m_pend);
    chk("b_sum_valid", b_sum_valid, m_pend);
    if (m_pend) begin
      chk("a_sum", a_sum, m_done % (64'd1 << 24));
      chk("a_sum_ovf", a_sum_ovf, m_done >= (64'd1 << 24));
      chk("b_sum", b_sum, m_done % (64'd1 << 16));
      chk("b_sum_ovf", b_sum_ovf, m_done >= (64'd1 << 16));
    end
  end

  task automatic drive(input bit pv, input logic [15:0] p, input logic [3:0] l,
                       input bit sr, input bit clr);
    prod_valid = pv; prod = p; len = l; sum_ready = sr; clear = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] t1 [4];
    logic [23:0] t3 [3];
    t1 = '{16'd10, 16'd20, 16'd30, 16'd40};
    t3 = '{24'd3, 24'd7, 24'd11};

    #1;
    chk("rst_sum_valid", a_sum_valid, 1'b0);
    chk("rst_prod_ready", a_prod_ready, 1'b0);
    chk("rst_sum", a_sum, 24'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_prod_ready", a_prod_ready, 1'b1);

    // Group of four
    foreach (t1[i]) drive(1, t1[i], 4'd3, 1, 0);
    prod_valid = 1'b0;
    chk("g4_valid", a_sum_valid, 1'b1);
    chk("g4_sum", a_sum, 24'd100);
    chk("g4_ovf", a_sum_ovf, 1'b0);
    drive(0, 0, 0, 1, 0);
    chk("g4_idle", a_sum_valid, 1'b0);

    // Single-product group held under backpressure
    drive(1, 16'hFFFF, 4'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum", a_sum, 24'h00FFFF);
      chk("bp_valid", a_sum_valid, 1'b1);
      chk("bp_prod_ready", a_prod_ready, 1'b0);
      drive(1, 16'h1234, 4'd0, 0, 0);
    end
    drive(0, 0, 0, 1, 0);
    chk("bp_drain", a_sum_valid, 1'b0);

    // Back-to-back pairs, no bubble
    for (int i = 1; i <= 6; i++) begin
      drive(1, 16'(i), 4'd1, 1, 0);
      if (i % 2 == 0) chk("b2b_sum", a_sum, t3[i/2-1]);
      chk("b2b_prod_ready", a_prod_ready, 1'b1);
    end
    drive(0, 0, 0, 1, 0);

    // Wrap in the 16-bit instance
    drive(1, 16'hFFFF, 4'd1, 1, 0);
    drive(1, 16'h0002, 4'd1, 1, 0);
    chk("ovf_b_sum", b_sum, 16'h0001);
    chk("ovf_b_flag", b_sum_ovf, 1'b1);
    chk("ovf_a_sum", a_sum, 24'h010001);
    chk("ovf_a_flag", a_sum_ovf, 1'b0);
    drive(1, 16'd1, 4'd1, 1, 0);
    drive(1, 16'd1, 4'd1, 1, 0);
    chk("ovf_next_sum", b_sum, 16'd2);
    chk("ovf_next_flag", b_sum_ovf, 1'b0);
    drive(0, 0, 0, 1, 0);

    // Bubbles, mid-group len change, then clear
    drive(1, 16'd5, 4'd3, 1, 0);
    drive(0, 0, 4'd0, 1, 0);
    drive(0, 0, 4'd0, 1, 0);
    drive(1, 16'd5, 4'd0, 1, 0);
    chk("len_ignored", a_sum_valid, 1'b0);
    drive(1, 16'd5, 4'd0, 1, 0);
    drive(0, 0, 4'd0, 1, 1);
    drive(0, 0, 4'd0, 1, 0);
    chk("clear_no_sum", a_sum_valid, 1'b0);
    drive(1, 16'd7, 4'd1, 1, 0);
    drive(1, 16'd8, 4'd1, 1, 0);
    chk("after_clear_sum", a_sum, 24'd15);
    drive(0, 0, 0, 1, 0);

    // Async reset while holding a sum
    drive(1, 16'd9, 4'd0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("hold_before_rst", a_sum_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", a_sum_valid, 1'b0);
    chk("async_rst_ready", a_prod_ready, 1'b0);
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("rel_prod_ready", a_prod_ready, 1'b1);
    @(posedge clk); #1;
    drive(1, 16'd4, 4'd1, 1, 0);
    drive(1, 16'd6, 4'd1, 1, 0);
    chk("post_rst_sum", a_sum, 24'd10);
    drive(0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
